// File: rtl/apb_regbank_slave.sv
// rtl/apb_regbank_slave.sv - APB4 slave with a DEPTH-word register bank and fixed wait-state insertion
module apb_regbank_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int SLV_ADDR_WIDTH = 8,
  parameter int DEPTH          = 48,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERROR
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                    state, state_next;
  logic [3:0]                cnt, cnt_next;
  logic [SLV_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [NBYTES-1:0]         strb_q;
  logic [DATA_WIDTH-1:0]     regs [0:DEPTH-1];

  logic                      access;
  logic                      latch_en;
  logic                      commit;
  logic                      resp_en;
  logic [SLV_ADDR_WIDTH-1:0] dec_addr;
  logic                      dec_write;
  logic [31:0]               idx32;
  logic [IDX_W-1:0]          widx;
  logic                      dec_err;
  logic                      pready_next;
  logic                      pslverror_next;
  logic [DATA_WIDTH-1:0]     prdata_next;
  logic                      unused_paddr_hi;

  assign access          = PSEL && PENABLE;
  assign unused_paddr_hi = ^PADDR[ADDR_WIDTH-1:SLV_ADDR_WIDTH];

  // With zero wait states the response is built in the setup cycle, before the latch holds the address.
  assign dec_addr  = (state == IDLE) ? PADDR[SLV_ADDR_WIDTH-1:0] : addr_q;
  assign dec_write = (state == IDLE) ? PWRITE : write_q;
  assign idx32     = 32'(dec_addr[SLV_ADDR_WIDTH-1:2]);
  assign widx      = idx32[IDX_W-1:0];
  assign dec_err   = (dec_addr[1:0] != 2'b00) || (idx32 >= 32'(DEPTH));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    commit     = 1'b0;
    resp_en    = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          latch_en = 1'b1;
          cnt_next = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            resp_en    = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!access) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_next = DONE;
          cnt_next   = 4'd0;
          resp_en    = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        commit     = access && write_q && !dec_err;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pready_next    = 1'b0;
    pslverror_next = 1'b0;
    prdata_next    = '0;
    if (resp_en) begin
      pready_next    = 1'b1;
      pslverror_next = dec_err;
      if (!dec_err && !dec_write) prdata_next = regs[widx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      PREADY    <= 1'b0;
      PSLVERROR <= 1'b0;
      PRDATA    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      PREADY    <= pready_next;
      PSLVERROR <= pslverror_next;
      PRDATA    <= prdata_next;
      if (latch_en) begin
        addr_q  <= PADDR[SLV_ADDR_WIDTH-1:0];
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
      if (commit) begin
        for (int b = 0; b < NBYTES; b++)
          if (strb_q[b]) regs[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb/tb_apb_regbank_slave.sv - scoreboard bench for apb_regbank_slave, 2 and 0 wait-state instances
module tb_apb_regbank_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite, which;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready_a, pslverror_a, pready_b, pslverror_b;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_m, pslverror_m;
  logic [31:0] prdata_m;

  always #5 clk = ~clk;

  apb_regbank_slave #(.WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .PSEL(psel & ~which), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready_a), .PRDATA(prdata_a), .PSLVERROR(pslverror_a)
  );

  apb_regbank_slave #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .PSEL(psel & which), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERROR(pslverror_b)
  );

  assign pready_m    = which ? pready_b    : pready_a;
  assign pslverror_m = which ? pslverror_b : pslverror_a;
  assign prdata_m    = which ? prdata_b    : prdata_a;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every PREADY cycle of the selected instance consumes one expected response.
  always @(negedge clk) begin : monitor
    resp_t r;
    if (!reset && pready_m) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pready: got pready=1 expected no response");
      end else begin
        r = exp_q.pop_front();
        check("prdata", prdata_m, r.data);
        check("pslverror", {31'b0, pslverror_m}, {31'b0, r.err});
      end
    end
  end

  task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_wait, input string name);
    int   n;
    logic bad;
    exp_q.push_back({exp_d, exp_e});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1'b1;
    n   = 0;
    bad = 1'b0;
    forever begin
      @(negedge clk);
      if (pready_m) break;
      if (prdata_m != 32'h0 || pslverror_m) bad = 1'b1;
      n++;
      if (n > 40) break;
    end
    check({name, "_wait"}, n, exp_wait);
    check({name, "_quiet"}, {31'b0, bad}, 32'h0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic expect_silent(input int cycles, input string name);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pready_m) hits++;
    end
    check(name, hits, 0);
  endtask

  initial begin
    reset = 1'b1; which = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready_a", {31'b0, pready_a}, 32'h0);
    check("rst_pslverror_a", {31'b0, pslverror_a}, 32'h0);
    check("rst_prdata_a", prdata_a, 32'h0);
    check("rst_pready_b", {31'b0, pready_b}, 32'h0);
    check("rst_prdata_b", prdata_b, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    xfer(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, "wr010");
    xfer(1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, "rd010");
    xfer(1'b1, 10'h020, 32'h11223344, 4'h5, 32'h0,        1'b0, 2, "wr020");
    xfer(1'b0, 10'h020, 32'h0,        4'h0, 32'h00220044, 1'b0, 2, "rd020");
    xfer(1'b1, 10'h0C0, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2, "wr0c0");
    xfer(1'b0, 10'h0C0, 32'h0,        4'h0, 32'h0,        1'b1, 2, "rd0c0");
    xfer(1'b0, 10'h013, 32'h0,        4'h0, 32'h0,        1'b1, 2, "rd013");
    xfer(1'b1, 10'h012, 32'h0BADF00D, 4'hF, 32'h0,        1'b1, 2, "wr012");
    xfer(1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, "rd010b");
    xfer(1'b0, 10'h0BC, 32'h0,        4'h0, 32'h0,        1'b0, 2, "rd0bc");
    xfer(1'b1, 10'h0BC, 32'h12345678, 4'hF, 32'h0,        1'b0, 2, "wr0bc");
    xfer(1'b0, 10'h0BC, 32'h0,        4'h0, 32'h12345678, 1'b0, 2, "rd0bcb");
    xfer(1'b0, 10'h310, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, "rd310");

    // Select dropped in the middle of the wait states.
    xfer(1'b1, 10'h008, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 2, "wr008");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h008; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    expect_silent(5, "psel_drop_silent");
    xfer(1'b0, 10'h008, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 2, "rd008");

    // Access phase without a setup phase is ignored.
    @(posedge clk); #1 psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h008; pwdata = 32'h0;
    expect_silent(4, "no_setup_silent");
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 10'h008, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 2, "rd008b");

    // Reset in the middle of a write's wait states.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h004; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_pready", {31'b0, pready_a}, 32'h0);
    @(posedge clk); #1 reset = 1'b0; psel = 1'b0; penable = 1'b0;
    expect_silent(4, "rst_mid_silent");
    xfer(1'b0, 10'h004, 32'h0, 4'h0, 32'h0, 1'b0, 2, "rd004");
    xfer(1'b0, 10'h010, 32'h0, 4'h0, 32'h0, 1'b0, 2, "rd010c");

    // Zero-wait instance, back-to-back transfers.
    @(posedge clk); #1 which = 1'b1;
    xfer(1'b1, 10'h000, 32'h01020304, 4'hF, 32'h0, 1'b0, 0, "b_wr000");
    xfer(1'b1, 10'h004, 32'h10203040, 4'hF, 32'h0, 1'b0, 0, "b_wr004");
    xfer(1'b1, 10'h008, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0, "b_wr008");
    xfer(1'b1, 10'h00C, 32'hFFFF0000, 4'hF, 32'h0, 1'b0, 0, "b_wr00c");
    xfer(1'b0, 10'h000, 32'h0, 4'h0, 32'h01020304, 1'b0, 0, "b_rd000");
    xfer(1'b0, 10'h004, 32'h0, 4'h0, 32'h10203040, 1'b0, 0, "b_rd004");
    xfer(1'b0, 10'h008, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0, "b_rd008");
    xfer(1'b0, 10'h00C, 32'h0, 4'h0, 32'hFFFF0000, 1'b0, 0, "b_rd00c");
    xfer(1'b1, 10'h000, 32'h99000000, 4'h8, 32'h0, 1'b0, 0, "b_wr000p");
    xfer(1'b0, 10'h000, 32'h0, 4'h0, 32'h99020304, 1'b0, 0, "b_rd000p");
    xfer(1'b0, 10'h0C1, 32'h0, 4'h0, 32'h0,        1'b1, 0, "b_rd0c1");

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
